// File: rtl/wb_arb_pkg.sv
// Shared types for the write-back port arbiter.
// Optional feature macro: WB_ARB_BYPASS_EN (empty-queue FPU bypass).
package wb_arb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 6;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    NORMAL = 1'b0,
    STALL  = 1'b1
  } wb_arb_state_t;

endpackage

// File: rtl/wb_arb_fifo.sv
// FPU result queue: synchronous FIFO, async active-low reset.
// Pointers wrap naturally because DEPTH is a power of two.
module wb_arb_fifo
  import wb_arb_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = wb_entry_t
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  entry_t                     push_data,
  input  logic                       pop,
  output entry_t                     head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: pipeline vs queued FPU results.
// Optional feature macro: WB_ARB_BYPASS_EN (empty-queue FPU bypass).
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_W       = WB_DATA_W,
  parameter int ADDR_W       = WB_ADDR_W,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            PipeWE,
  input  logic [ADDR_W-1:0]               PipeAddr,
  input  logic [DATA_W-1:0]               PipeData,
  input  logic                            FpuValid,
  input  logic [ADDR_W-1:0]               FpuAddr,
  input  logic [DATA_W-1:0]               FpuData,
  output logic                            FpuReady,
  output logic                            PipeStall,
  output logic                            RegWBWE,
  output logic [ADDR_W-1:0]               RegWBAddr,
  output logic [DATA_W-1:0]               RegWBData,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] QueueCount
);

  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int WW = $clog2(STARVE_LIMIT);

  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [WW-1:0] WAIT_MAX = WW'(STARVE_LIMIT-1);

`ifdef WB_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  wb_arb_state_t state;
  logic [WW-1:0] wait_cnt;

  entry_t head;
  entry_t fpu_in;
  logic   q_empty;
  logic   push;
  logic   fifo_push;
  logic   pop;
  logic   pipe_gnt;
  logic   byp_gnt;
  logic   starve;

  assign FpuReady  = (QueueCount != FULL_CNT);
  assign push      = FpuValid && FpuReady;
  assign q_empty   = (QueueCount == '0);
  assign fpu_in    = '{addr: FpuAddr, data: FpuData};
  assign fifo_push = push && !byp_gnt;

  always_comb begin
    pipe_gnt = 1'b0;
    pop      = 1'b0;
    byp_gnt  = 1'b0;
    unique case (1'b1)
      state == STALL:
        pop = !q_empty;
      state == NORMAL && PipeWE:
        pipe_gnt = 1'b1;
      state == NORMAL && !PipeWE && !q_empty:
        pop = 1'b1;
      default:
        byp_gnt = BYP && push;
    endcase
  end

  // Head has waited its full budget and is losing again this cycle.
  assign starve = (state == NORMAL) && !q_empty
               && !pop && (wait_cnt == WAIT_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= NORMAL;
      PipeStall <= 1'b0;
      wait_cnt  <= '0;
      RegWBWE   <= 1'b0;
      RegWBAddr <= '0;
      RegWBData <= '0;
    end else begin
      unique case (state)
        NORMAL: begin
          if (starve) begin
            state     <= STALL;
            PipeStall <= 1'b1;
          end
        end
        STALL: begin
          state     <= NORMAL;
          PipeStall <= 1'b0;
        end
      endcase

      if (q_empty || pop) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WAIT_MAX) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      RegWBWE <= pipe_gnt || pop || byp_gnt;
      if (pipe_gnt) begin
        RegWBAddr <= PipeAddr;
        RegWBData <= PipeData;
      end else if (pop) begin
        RegWBAddr <= head.addr;
        RegWBData <= head.data;
      end else if (byp_gnt) begin
        RegWBAddr <= FpuAddr;
        RegWBData <= FpuData;
      end
    end
  end

  wb_arb_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (fpu_in),
    .pop       (pop),
    .head      (head),
    .count     (QueueCount)
  );

endmodule
